// File: rtl/vga_sync.sv
// VGA timing generator: free-running pixel/line counters with phase FSMs,
// producing registered position, sync, visibility and start-of-line/frame pulses.
module vga_sync #(
  parameter int unsigned H_VISIBLE = 640,
  parameter int unsigned H_FRONT   = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BACK    = 48,
  parameter int unsigned V_VISIBLE = 480,
  parameter int unsigned V_FRONT   = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BACK    = 33
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pixel_en_i,
  output logic [9:0] column_o,
  output logic [9:0] row_o,
  output logic       hsync_o,
  output logic       vsync_o,
  output logic       visible_o,
  output logic       line_start_o,
  output logic       frame_start_o
);

  localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
  localparam logic [9:0] H_FP_START = 10'(H_VISIBLE);
  localparam logic [9:0] H_SY_START = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] H_BP_START = 10'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
  localparam logic [9:0] V_FP_START = 10'(V_VISIBLE);
  localparam logic [9:0] V_SY_START = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] V_BP_START = 10'(V_VISIBLE + V_FRONT + V_SYNC);

  localparam logic [1:0] H_VIS = 2'd0;
  localparam logic [1:0] H_FP  = 2'd1;
  localparam logic [1:0] H_SY  = 2'd2;
  localparam logic [1:0] H_BP  = 2'd3;
  localparam logic [1:0] V_VIS = 2'd0;
  localparam logic [1:0] V_FP  = 2'd1;
  localparam logic [1:0] V_SY  = 2'd2;
  localparam logic [1:0] V_BP  = 2'd3;

  logic [9:0] h_cnt_reg, h_cnt_next;
  logic [9:0] v_cnt_reg, v_cnt_next;
  logic [1:0] h_state_reg, h_state_next;
  logic [1:0] v_state_reg, v_state_next;
  logic       h_wrap, v_wrap;

  // Each FSM state always names the phase its counter is currently in.
  always_comb begin
    h_wrap       = (h_cnt_reg == H_LAST);
    v_wrap       = (v_cnt_reg == V_LAST);
    h_cnt_next   = h_wrap ? 10'd0 : h_cnt_reg + 10'd1;
    v_cnt_next   = v_cnt_reg;
    h_state_next = h_state_reg;
    v_state_next = v_state_reg;

    if (h_cnt_next == H_FP_START)      h_state_next = H_FP;
    else if (h_cnt_next == H_SY_START) h_state_next = H_SY;
    else if (h_cnt_next == H_BP_START) h_state_next = H_BP;
    else if (h_cnt_next == 10'd0)      h_state_next = H_VIS;

    if (h_wrap) begin
      v_cnt_next = v_wrap ? 10'd0 : v_cnt_reg + 10'd1;
      if (v_cnt_next == V_FP_START)      v_state_next = V_FP;
      else if (v_cnt_next == V_SY_START) v_state_next = V_SY;
      else if (v_cnt_next == V_BP_START) v_state_next = V_BP;
      else if (v_cnt_next == 10'd0)      v_state_next = V_VIS;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      h_cnt_reg     <= 10'd0;
      v_cnt_reg     <= 10'd0;
      h_state_reg   <= H_VIS;
      v_state_reg   <= V_VIS;
      column_o      <= 10'd0;
      row_o         <= 10'd0;
      hsync_o       <= 1'b1;
      vsync_o       <= 1'b1;
      visible_o     <= 1'b0;
      line_start_o  <= 1'b0;
      frame_start_o <= 1'b0;
    end else begin
      line_start_o  <= 1'b0;
      frame_start_o <= 1'b0;
      if (pixel_en_i) begin
        h_cnt_reg     <= h_cnt_next;
        v_cnt_reg     <= v_cnt_next;
        h_state_reg   <= h_state_next;
        v_state_reg   <= v_state_next;
        // Outputs decode the pre-increment position: one enabled cycle of latency.
        column_o      <= h_cnt_reg;
        row_o         <= v_cnt_reg;
        hsync_o       <= (h_state_reg != H_SY);
        vsync_o       <= (v_state_reg != V_SY);
        visible_o     <= (h_state_reg == H_VIS) && (v_state_reg == V_VIS);
        line_start_o  <= (h_cnt_reg == 10'd0);
        frame_start_o <= (h_cnt_reg == 10'd0) && (v_cnt_reg == 10'd0);
      end
    end
  end

endmodule

// File: tb/tb_vga_sync.sv
// Directed bench: a reduced-geometry instance (32x20 frame) exercised by a vector
// table and whole-frame sequences, plus a default-geometry instance for line timing.
module tb_vga_sync;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic en = 1'b0;
  always #5 clk = ~clk;

  // Reduced geometry: H 16/4/6/6 (total 32, hsync cols 20..25), V 12/2/2/4 (total 20, vsync rows 14..15).
  logic [9:0] s_col, s_row;
  logic       s_hs, s_vs, s_vis, s_ls, s_fs;
  vga_sync #(
    .H_VISIBLE(16), .H_FRONT(4), .H_SYNC(6), .H_BACK(6),
    .V_VISIBLE(12), .V_FRONT(2), .V_SYNC(2), .V_BACK(4)
  ) dut (
    .clk(clk), .reset(reset), .pixel_en_i(en),
    .column_o(s_col), .row_o(s_row), .hsync_o(s_hs), .vsync_o(s_vs),
    .visible_o(s_vis), .line_start_o(s_ls), .frame_start_o(s_fs)
  );

  logic [9:0] d_col, d_row;
  logic       d_hs, d_vs, d_vis, d_ls, d_fs;
  vga_sync dut_def (
    .clk(clk), .reset(reset), .pixel_en_i(en),
    .column_o(d_col), .row_o(d_row), .hsync_o(d_hs), .vsync_o(d_vs),
    .visible_o(d_vis), .line_start_o(d_ls), .frame_start_o(d_fs)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    logic rst;
    logic en;
    int   n;
    int   col;
    int   row;
    logic hs;
    logic vs;
    logic vis;
    logic ls;
    logic fs;
  } vec_t;

  function automatic vec_t mk(input logic r, input logic e, input int n, input int c, input int rw,
                              input logic hs, input logic vs, input logic vis, input logic ls, input logic fs);
    vec_t v;
    v.rst = r; v.en = e; v.n = n; v.col = c; v.row = rw;
    v.hs = hs; v.vs = vs; v.vis = vis; v.ls = ls; v.fs = fs;
    return v;
  endfunction

  task automatic pulse_reset();
    reset = 1'b1;
    en = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  vec_t vecs[23];

  initial begin
    // rst en  n    col row hs vs vis ls fs
    vecs[0]  = mk(1, 1, 2,    0,  0, 1, 1, 0, 0, 0);
    vecs[1]  = mk(0, 1, 1,    0,  0, 1, 1, 1, 1, 1);
    vecs[2]  = mk(0, 0, 1,    0,  0, 1, 1, 1, 0, 0);
    vecs[3]  = mk(0, 1, 15,  15,  0, 1, 1, 1, 0, 0);
    vecs[4]  = mk(0, 1, 1,   16,  0, 1, 1, 0, 0, 0);
    vecs[5]  = mk(0, 1, 4,   20,  0, 0, 1, 0, 0, 0);
    vecs[6]  = mk(0, 1, 5,   25,  0, 0, 1, 0, 0, 0);
    vecs[7]  = mk(0, 1, 1,   26,  0, 1, 1, 0, 0, 0);
    vecs[8]  = mk(0, 1, 5,   31,  0, 1, 1, 0, 0, 0);
    vecs[9]  = mk(0, 1, 1,    0,  1, 1, 1, 1, 1, 0);
    vecs[10] = mk(0, 0, 3,    0,  1, 1, 1, 1, 0, 0);
    vecs[11] = mk(0, 1, 335, 15, 11, 1, 1, 1, 0, 0);
    vecs[12] = mk(0, 1, 1,   16, 11, 1, 1, 0, 0, 0);
    vecs[13] = mk(0, 1, 31,  15, 12, 1, 1, 0, 0, 0);
    vecs[14] = mk(0, 1, 49,   0, 14, 1, 0, 0, 1, 0);
    vecs[15] = mk(0, 1, 63,  31, 15, 1, 0, 0, 0, 0);
    vecs[16] = mk(0, 1, 1,    0, 16, 1, 1, 0, 1, 0);
    vecs[17] = mk(0, 1, 127, 31, 19, 1, 1, 0, 0, 0);
    vecs[18] = mk(0, 1, 1,    0,  0, 1, 1, 1, 1, 1);
    vecs[19] = mk(0, 1, 170, 10,  5, 1, 1, 1, 0, 0);
    vecs[20] = mk(1, 1, 1,    0,  0, 1, 1, 0, 0, 0);
    vecs[21] = mk(0, 0, 1,    0,  0, 1, 1, 0, 0, 0);
    vecs[22] = mk(0, 1, 1,    0,  0, 1, 1, 1, 1, 1);

    #1;
    for (int i = 0; i < 23; i++) begin
      reset = vecs[i].rst;
      en = vecs[i].en;
      repeat (vecs[i].n) @(posedge clk);
      #1;
      $display("vec %0d: rst=%0b en=%0b n=%0d -> col=%0d row=%0d hs=%0b vs=%0b vis=%0b ls=%0b fs=%0b",
               i, vecs[i].rst, vecs[i].en, vecs[i].n, s_col, s_row, s_hs, s_vs, s_vis, s_ls, s_fs);
      chk($sformatf("vec%0d_col", i), int'(s_col), vecs[i].col);
      chk($sformatf("vec%0d_row", i), int'(s_row), vecs[i].row);
      chk($sformatf("vec%0d_hsync", i), int'(s_hs), int'(vecs[i].hs));
      chk($sformatf("vec%0d_vsync", i), int'(s_vs), int'(vecs[i].vs));
      chk($sformatf("vec%0d_visible", i), int'(s_vis), int'(vecs[i].vis));
      chk($sformatf("vec%0d_line_start", i), int'(s_ls), int'(vecs[i].ls));
      chk($sformatf("vec%0d_frame_start", i), int'(s_fs), int'(vecs[i].fs));
    end

    // Two full frames at constant enable; default instance covers its first 1.6 lines.
    begin
      int fs_cnt = 0, last_fs = -1, fs_int = 0;
      int ls_cnt = 0, last_ls = -1, ls_bad = 0;
      int vis_cnt = 0, hs_low = 0, hs_bad_start = 0, vs_low = 0;
      int d_ls_cnt = 0, d_last_ls = -1, d_ls_int = 0;
      int d_hs_low = 0, d_hs_first = -1, d_vs_low = 0;
      int d_vis639 = 0, d_vis640 = 1;
      logic prev_hs = 1'b1;
      pulse_reset();
      chk("def_reset_col", int'(d_col), 0);
      chk("def_reset_hsync", int'(d_hs), 1);
      chk("def_reset_visible", int'(d_vis), 0);
      chk("def_reset_frame_start", int'(d_fs), 0);
      for (int k = 1; k <= 1280; k++) begin
        en = 1'b1;
        @(posedge clk);
        #1;
        if (s_fs) begin
          fs_cnt++;
          if (last_fs >= 0) fs_int = k - last_fs;
          last_fs = k;
        end
        if (s_ls) begin
          ls_cnt++;
          if (last_ls >= 0 && k - last_ls != 32) ls_bad++;
          last_ls = k;
        end
        if (s_vis) vis_cnt++;
        if (!s_hs) begin
          hs_low++;
          if (prev_hs && s_col != 10'd20) hs_bad_start++;
        end
        prev_hs = s_hs;
        if (!s_vs) vs_low++;
        if (d_ls) begin
          d_ls_cnt++;
          if (d_last_ls >= 0) d_ls_int = k - d_last_ls;
          d_last_ls = k;
        end
        if (!d_hs) begin
          d_hs_low++;
          if (d_hs_first < 0) d_hs_first = int'(d_col);
        end
        if (!d_vs) d_vs_low++;
        if (d_col == 10'd639 && d_row == 10'd0) d_vis639 = int'(d_vis);
        if (d_col == 10'd640 && d_row == 10'd0) d_vis640 = int'(d_vis);
      end
      $display("frames: fs=%0d int=%0d ls=%0d vis=%0d hs_low=%0d vs_low=%0d", fs_cnt, fs_int, ls_cnt, vis_cnt, hs_low, vs_low);
      chk("frame_start_count", fs_cnt, 2);
      chk("frame_start_interval", fs_int, 640);
      chk("line_start_count", ls_cnt, 40);
      chk("line_start_bad_interval", ls_bad, 0);
      chk("visible_cycles", vis_cnt, 384);
      chk("hsync_low_cycles", hs_low, 240);
      chk("hsync_bad_start", hs_bad_start, 0);
      chk("vsync_low_cycles", vs_low, 128);
      $display("default: ls=%0d int=%0d hs_low=%0d first=%0d", d_ls_cnt, d_ls_int, d_hs_low, d_hs_first);
      chk("def_line_start_count", d_ls_cnt, 2);
      chk("def_line_interval", d_ls_int, 800);
      chk("def_hsync_low_cycles", d_hs_low, 96);
      chk("def_hsync_first_col", d_hs_first, 656);
      chk("def_vsync_low_cycles", d_vs_low, 0);
      chk("def_visible_col639", d_vis639, 1);
      chk("def_visible_col640", d_vis640, 0);
    end

    // Enable toggling every clk: timing doubles, outputs hold, pulses stay 1 clk wide.
    begin
      int fs_cnt = 0, last_fs = -1, fs_int = 0;
      int ls_hi = 0, ls_wide = 0, hold_bad = 0, vis_cnt = 0, pulse_bad = 0;
      logic [9:0] p_col = 10'd0, p_row = 10'd0;
      logic p_hs = 1'b1, p_vs = 1'b1, p_vis = 1'b0, p_ls = 1'b0;
      pulse_reset();
      for (int c = 0; c < 2560; c++) begin
        en = (c % 2 == 0);
        @(posedge clk);
        #1;
        if (s_fs) begin
          fs_cnt++;
          if (last_fs >= 0) fs_int = c - last_fs;
          last_fs = c;
        end
        if (s_ls) begin
          ls_hi++;
          if (p_ls) ls_wide++;
        end
        if (s_vis) vis_cnt++;
        if (c % 2 == 1) begin
          if (s_col != p_col || s_row != p_row || s_hs != p_hs || s_vs != p_vs || s_vis != p_vis)
            hold_bad++;
          if (s_ls || s_fs) pulse_bad++;
        end
        p_col = s_col; p_row = s_row; p_hs = s_hs; p_vs = s_vs; p_vis = s_vis; p_ls = s_ls;
      end
      $display("toggle: fs=%0d int=%0d ls=%0d vis=%0d hold_bad=%0d", fs_cnt, fs_int, ls_hi, vis_cnt, hold_bad);
      chk("toggle_frame_start_count", fs_cnt, 2);
      chk("toggle_frame_interval", fs_int, 1280);
      chk("toggle_line_start_high", ls_hi, 40);
      chk("toggle_line_start_wide", ls_wide, 0);
      chk("toggle_pulse_on_disabled", pulse_bad, 0);
      chk("toggle_hold_bad", hold_bad, 0);
      chk("toggle_visible_cycles", vis_cnt, 768);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
